// File: rtl/serial_div_pkg.sv
// Shared constants, beat decode type and a reference remainder step for the
// serial divisibility checker family.
package serial_div_pkg;

    localparam int unsigned DIVISOR_MIN = 2;
    localparam int unsigned DIVISOR_MAX = 255;
    localparam int unsigned DIGIT_W_MIN = 1;
    localparam int unsigned DIGIT_W_MAX = 8;
    localparam int unsigned REM_W_MAX   = 8;

    // What an input beat does to the remainder register.
    typedef enum logic [1:0] {
        BEAT_HOLD,
        BEAT_STEP,
        BEAT_CLEAR
    } beat_op_e;

    // One MSB-first bit step at maximum width: r' = (2r + b) mod divisor,
    // valid whenever r < divisor.
    function automatic logic [REM_W_MAX-1:0] rem_step(
        input logic [REM_W_MAX-1:0] rem,
        input logic                 din,
        input logic [REM_W_MAX:0]   divisor
    );
        logic [REM_W_MAX:0] t;
        t = {rem, din};
        if (t >= divisor) begin
            t = t - divisor;
        end
        return t[REM_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/serial_div_step.sv
// One conditional-subtract stage: shifts one bit into a remainder that is
// already below DIVISOR and reduces it back below DIVISOR.
module serial_div_step #(
    parameter  int unsigned DIVISOR = 5,
    localparam int unsigned REM_W   = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] rem_i,
    input  logic             bit_i,
    output logic [REM_W-1:0] rem_o
);

    localparam logic [REM_W:0] DIV_T = DIVISOR[REM_W:0];

    logic [REM_W:0] t;
    logic [REM_W:0] diff;

    // 2r + b is below 2*DIVISOR, so a single subtract suffices.
    always_comb begin
        t     = {rem_i, bit_i};
        diff  = t - DIV_T;
        rem_o = (t >= DIV_T) ? diff[REM_W-1:0] : t[REM_W-1:0];
    end

endmodule

// File: rtl/serial_divisibility_by_n_fsm.sv
// Serial divisibility checker: tracks an MSB-first number's remainder modulo
// DIVISOR, DIGIT_W bits per beat, with start/last framing and latched results.
module serial_divisibility_by_n_fsm
    import serial_div_pkg::*;
#(
    parameter  int unsigned DIVISOR = 5,
    parameter  int unsigned DIGIT_W = 1,
    localparam int unsigned REM_W   = $clog2(DIVISOR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_start,
    input  logic               in_last,
    input  logic [DIGIT_W-1:0] in_digit,
    output logic [REM_W-1:0]   rem,
    output logic               div_by_n,
    output logic               done,
    output logic               result_div,
    output logic [REM_W-1:0]   result_rem
);

    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
        $error("serial_divisibility_by_n_fsm: DIVISOR %0d outside 2..255", DIVISOR);
    end
    if (DIGIT_W < DIGIT_W_MIN || DIGIT_W > DIGIT_W_MAX) begin : g_bad_digit_w
        $error("serial_divisibility_by_n_fsm: DIGIT_W %0d outside 1..8", DIGIT_W);
    end

    logic [REM_W-1:0] rem_q, rem_d;
    logic [REM_W-1:0] res_rem_q, res_rem_d;
    logic             res_div_q, res_div_d;
    logic             done_q, done_d;
    logic [REM_W-1:0] base;
    logic [REM_W-1:0] rem_next;
    beat_op_e         beat_op;

    assign base = in_start ? '0 : rem_q;

    // Chain of DIGIT_W 1-bit stages, earliest (MSB) digit bit first.
    for (genvar i = 0; i < DIGIT_W; i++) begin : g_stage
        logic [REM_W-1:0] r_in;
        logic [REM_W-1:0] r_out;
        if (i == 0) begin : g_first
            assign r_in = base;
        end else begin : g_next
            assign r_in = g_stage[i-1].r_out;
        end
        serial_div_step #(.DIVISOR(DIVISOR)) u_step (
            .rem_i (r_in),
            .bit_i (in_digit[DIGIT_W-1-i]),
            .rem_o (r_out)
        );
    end

    assign rem_next = g_stage[DIGIT_W-1].r_out;

    // Decode the beat and compute next remainder, done pulse and results.
    always_comb begin
        beat_op   = BEAT_HOLD;
        rem_d     = rem_q;
        done_d    = 1'b0;
        res_rem_d = res_rem_q;
        res_div_d = res_div_q;
        if (in_valid) begin
            beat_op = BEAT_STEP;
        end else if (in_start) begin
            beat_op = BEAT_CLEAR;
        end
        case (beat_op)
            BEAT_STEP: begin
                rem_d = rem_next;
                if (in_last) begin
                    done_d    = 1'b1;
                    res_rem_d = rem_next;
                    res_div_d = (rem_next == '0);
                end
            end
            BEAT_CLEAR: rem_d = '0;
            default:    rem_d = rem_q;
        endcase
    end

    // State and result registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            done_q    <= 1'b0;
            res_rem_q <= '0;
            res_div_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            done_q    <= done_d;
            res_rem_q <= res_rem_d;
            res_div_q <= res_div_d;
        end
    end

    assign rem        = rem_q;
    assign div_by_n   = (rem_q == '0);
    assign done       = done_q;
    assign result_div = res_div_q;
    assign result_rem = res_rem_q;

endmodule

// File: tb/tb_serial_divisibility_by_n_fsm.sv
// Self-checking bench: directed framing scenarios on two instances plus
// randomized 64-bit numbers on a grid of DIVISOR x DIGIT_W instances,
// checked against value % DIVISOR computed directly.
module tb_serial_divisibility_by_n_fsm;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- directed instance A: DIVISOR=5, DIGIT_W=1
    logic       rst = 1'b1;
    logic       a_valid = 0, a_start = 0, a_last = 0;
    logic [0:0] a_digit = '0;
    logic [2:0] a_rem, a_rrem;
    logic       a_div, a_done, a_rdiv;

    serial_divisibility_by_n_fsm #(.DIVISOR(5), .DIGIT_W(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_start(a_start), .in_last(a_last),
        .in_digit(a_digit), .rem(a_rem), .div_by_n(a_div), .done(a_done),
        .result_div(a_rdiv), .result_rem(a_rrem)
    );

    // ---------------- directed instance B: DIVISOR=7, DIGIT_W=4
    logic       b_valid = 0, b_start = 0, b_last = 0;
    logic [3:0] b_digit = '0;
    logic [2:0] b_rem, b_rrem;
    logic       b_div, b_done, b_rdiv;

    serial_divisibility_by_n_fsm #(.DIVISOR(7), .DIGIT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_start(b_start), .in_last(b_last),
        .in_digit(b_digit), .rem(b_rem), .div_by_n(b_div), .done(b_done),
        .result_div(b_rdiv), .result_rem(b_rrem)
    );

    task automatic drive_a(input logic r, input logic v, input logic s, input logic l, input logic d);
        @(negedge clk);
        rst = r; a_valid = v; a_start = s; a_last = l; a_digit[0] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic s, input logic l, input logic [3:0] d);
        @(negedge clk);
        b_valid = v; b_start = s; b_last = l; b_digit = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int unsigned rem_e, input int unsigned done_e,
                           input int unsigned rdiv_e, input int unsigned rrem_e);
        check({tag, " rem"},      a_rem,  rem_e);
        check({tag, " div_by_n"}, a_div,  (rem_e == 0) ? 1 : 0);
        check({tag, " done"},     a_done, done_e);
        check({tag, " res_div"},  a_rdiv, rdiv_e);
        check({tag, " res_rem"},  a_rrem, rrem_e);
    endtask

    task automatic check_b(input string tag, input int unsigned rem_e, input int unsigned done_e,
                           input int unsigned rdiv_e, input int unsigned rrem_e);
        check({tag, " rem"},      b_rem,  rem_e);
        check({tag, " div_by_n"}, b_div,  (rem_e == 0) ? 1 : 0);
        check({tag, " done"},     b_done, done_e);
        check({tag, " res_div"},  b_rdiv, rdiv_e);
        check({tag, " res_rem"},  b_rrem, rrem_e);
    endtask

    // ---------------- randomized grid
    localparam logic [5:0][7:0] DIVS = {8'd255, 8'd13, 8'd7, 8'd5, 8'd3, 8'd2};
    localparam logic [2:0][7:0] WS   = {8'd8, 8'd3, 8'd1};
    localparam int unsigned     N_RAND_INST = 18;

    logic        rst_r    = 1'b1;
    logic        rand_go  = 1'b0;
    int unsigned rand_done = 0;

    for (genvar a = 0; a < 6; a++) begin : g_d
        for (genvar b = 0; b < 3; b++) begin : g_w
            localparam int unsigned D  = 32'(DIVS[a]);
            localparam int unsigned W  = 32'(WS[b]);
            localparam int unsigned RW = $clog2(D);

            logic          valid = 0, start = 0, last = 0;
            logic [W-1:0]  digit = '0;
            logic [RW-1:0] rem, rrem;
            logic          dbn, dn, rdiv;

            serial_divisibility_by_n_fsm #(.DIVISOR(D), .DIGIT_W(W)) u_dut (
                .clk(clk), .rst(rst_r), .in_valid(valid), .in_start(start), .in_last(last),
                .in_digit(digit), .rem(rem), .div_by_n(dbn), .done(dn),
                .result_div(rdiv), .result_rem(rrem)
            );

            initial begin
                longint unsigned value, prefix;
                int unsigned     exp_rem, nb;
                string           tg;
                tg = $sformatf("rand D%0d W%0d", D, W);
                wait (rand_go);
                check({tg, " reset rem"}, rem, 0);
                check({tg, " reset res_rem"}, rrem, 0);
                exp_rem = 0;
                for (int n = 0; n < 12; n++) begin
                    value = {$urandom, $urandom};
                    nb    = (64 + W - 1) / W;
                    for (int k = int'(nb) - 1; k >= 0; k--) begin
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) begin
                                @(negedge clk);
                                valid = 0; start = 0; last = 1'($urandom_range(0, 1));
                                digit = W'($urandom);
                                @(posedge clk);
                                #1;
                                check({tg, " gap rem"}, rem, exp_rem);
                                check({tg, " gap done"}, dn, 0);
                            end
                        end
                        prefix = value >> (k * W);
                        @(negedge clk);
                        valid = 1; start = (k == int'(nb) - 1); last = (k == 0);
                        digit = prefix[W-1:0];
                        @(posedge clk);
                        #1;
                        exp_rem = 32'(prefix % D);
                        check({tg, " rem"}, rem, exp_rem);
                        check({tg, " div_by_n"}, dbn, (exp_rem == 0) ? 1 : 0);
                        if (k == 0) begin
                            check({tg, " done"}, dn, 1);
                            check({tg, " res_rem"}, rrem, 32'(value % D));
                            check({tg, " res_div"}, rdiv, ((value % D) == 0) ? 1 : 0);
                        end else begin
                            check({tg, " mid done"}, dn, 0);
                        end
                    end
                end
                @(negedge clk);
                valid = 0; start = 0; last = 0;
                rand_done++;
            end
        end
    end

    // ---------------- directed sequence
    initial begin
        int unsigned cyc;
        repeat (3) @(posedge clk);
        #1;
        check_a("reset A", 0, 0, 0, 0);
        check_b("reset B", 0, 0, 0, 0);

        // 1: 1010 = 10, divisible by 5
        drive_a(0, 1, 1, 0, 1); check_a("t1 b0", 1, 0, 0, 0);
        drive_a(0, 1, 0, 0, 0); check_a("t1 b1", 2, 0, 0, 0);
        drive_a(0, 1, 0, 0, 1); check_a("t1 b2", 0, 0, 0, 0);
        drive_a(0, 1, 0, 1, 0); check_a("t1 b3", 0, 1, 1, 0);
        drive_a(0, 0, 0, 0, 0); check_a("t1 idle", 0, 0, 1, 0);

        // 2: 111 = 7 -> 2, then back-to-back single-beat numbers 0 and 1
        drive_a(0, 1, 1, 0, 1); check_a("t2 b0", 1, 0, 1, 0);
        drive_a(0, 1, 0, 0, 1); check_a("t2 b1", 3, 0, 1, 0);
        drive_a(0, 1, 0, 1, 1); check_a("t2 b2", 2, 1, 0, 2);
        drive_a(0, 1, 1, 1, 0); check_a("b2b zero", 0, 1, 1, 0);
        drive_a(0, 1, 1, 1, 1); check_a("b2b one", 1, 1, 0, 1);

        // 4: idle gaps hold, in_last ignored while invalid, then abort-clear
        drive_a(0, 1, 1, 0, 1); check_a("t4 b0", 1, 0, 0, 1);
        drive_a(0, 1, 0, 0, 1); check_a("t4 b1", 3, 0, 0, 1);
        drive_a(0, 0, 0, 1, 0); check_a("t4 gap0", 3, 0, 0, 1);
        drive_a(0, 0, 0, 0, 1); check_a("t4 gap1", 3, 0, 0, 1);
        drive_a(0, 0, 0, 1, 1); check_a("t4 gap2", 3, 0, 0, 1);
        drive_a(0, 1, 0, 0, 0); check_a("t4 b2", 1, 0, 0, 1);
        drive_a(0, 0, 1, 1, 1); check_a("t4 clear", 0, 0, 0, 1);

        // 5: reset in the middle of 1101, then 1101 = 13 -> 3
        drive_a(0, 1, 1, 0, 1); check_a("t5 b0", 1, 0, 0, 1);
        drive_a(0, 1, 0, 0, 1); check_a("t5 b1", 3, 0, 0, 1);
        drive_a(1, 1, 0, 1, 0); check_a("t5 rst", 0, 0, 0, 0);
        drive_a(0, 1, 0, 1, 1); check_a("t5 after rst", 1, 1, 0, 1);
        drive_a(0, 1, 1, 0, 1); check_a("t5 r0", 1, 0, 0, 1);
        drive_a(0, 1, 0, 0, 1); check_a("t5 r1", 3, 0, 0, 1);
        drive_a(0, 1, 0, 0, 0); check_a("t5 r2", 1, 0, 0, 1);
        drive_a(0, 1, 0, 1, 1); check_a("t5 r3", 3, 1, 0, 3);
        drive_a(0, 0, 0, 0, 0); check_a("t5 idle", 3, 0, 0, 3);

        // 3: DIVISOR=7, DIGIT_W=4; 0xA5 = 165 -> 4, then single-beat 0xE -> 0
        drive_b(1, 1, 0, 4'hA); check_b("t3 d0", 3, 0, 0, 0);
        drive_b(1, 0, 1, 4'h5); check_b("t3 d1", 4, 1, 0, 4);
        drive_b(1, 1, 1, 4'hE); check_b("t3 single", 0, 1, 1, 0);
        drive_b(0, 0, 0, 4'h0); check_b("t3 idle", 0, 0, 1, 0);
        // restart mid-number discards the partial remainder: 0x3 then 0x92 = 146 -> 6
        drive_b(1, 1, 0, 4'h3); check_b("t3 part", 3, 0, 1, 0);
        drive_b(1, 1, 0, 4'h9); check_b("t3 restart", 2, 0, 1, 0);
        drive_b(1, 0, 1, 4'h2); check_b("t3 restart last", 6, 1, 0, 6);
        drive_b(0, 0, 0, 4'h0); check_b("t3 end", 6, 0, 0, 6);

        // 6: randomized grid
        @(negedge clk);
        rst_r = 1'b0;
        @(negedge clk);
        rand_go = 1'b1;
        cyc = 0;
        while (rand_done < N_RAND_INST && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        check("rand all instances finished", rand_done, N_RAND_INST);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
